// File: rtl/rca_mw_pkg.sv
// Shared types and helpers for the multi-word sequential adder.
package rca_mw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word index width; a single-word configuration still needs a 1-bit index.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/rca_mw_adder_rca.sv
// N-bit combinational ripple-carry adder, one full adder per bit.
module rca #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < N; i++) begin
      sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry[N];
  end

endmodule

// File: rtl/rca_mw_adder.sv
// Multi-word sequential adder: streams W-bit operands through one N-bit
// ripple-carry adder, least-significant word first, carry held in a flop.
module rca_mw_adder
  import rca_mw_pkg::*;
#(
  parameter int N     = 32,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WORDS-1:0]   a_i,
  input  logic [N*WORDS-1:0]   b_i,
  input  logic                 cin_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*WORDS-1:0]   sum_o,
  output logic                 cout_o,
  output logic                 ovf_o,
  output state_t               dbg_state_o
);

  localparam int W  = N * WORDS;
  localparam int IW = idx_width(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready depends on state only; out_valid and the result stay stable
  // until out_ready is seen, and no new pair is taken while one is pending.

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            ovf_q, ovf_d;

  logic [N-1:0]    word_a;
  logic [N-1:0]    word_b;
  logic [N-1:0]    word_sum;
  logic            word_cout;

  assign word_a = a_q[idx_q*N +: N];
  assign word_b = b_q[idx_q*N +: N];

  rca #(.N(N)) u_rca (
    .a_i    (word_a),
    .b_i    (word_b),
    .cin_i  (carry_q),
    .sum_o  (word_sum),
    .cout_o (word_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*N +: N] = word_sum;
        carry_d             = word_cout;
        if (idx_q == LAST_IDX) begin
          // Signed overflow: operands agree in sign but the result does not.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (word_sum[N-1] != a_q[W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign sum_o       = sum_q;
  assign cout_o      = carry_q;
  assign ovf_o       = ovf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rca_mw_adder.sv
// Directed and randomized bench for rca_mw_adder (N=32, WORDS=4).
module tb_rca_mw_adder;
  import rca_mw_pkg::*;

  localparam int N     = 32;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_o;
  logic         cout_o;
  logic         ovf_o;
  state_t       dbg_state;

  always #5 clk = ~clk;

  rca_mw_adder #(.N(N), .WORDS(WORDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_i         (a_i),
    .b_i         (b_i),
    .cin_i       (cin_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum_o       (sum_o),
    .cout_o      (cout_o),
    .ovf_o       (ovf_o),
    .dbg_state_o (dbg_state)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total_cnt = 0;
  int pass_cnt  = 0;
  logic [W+1:0] exp_q[$];

  task automatic chk(input string tag, input logic [W+1:0] obs, input logic [W+1:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // {ovf, cout, sum} of a full-width reference addition
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
    logic [W:0] s;
    logic       ovf;
    s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {ovf, s};
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < WORDS; i++) begin
      case ($urandom_range(0, 5))
        0:       v[i*N +: N] = '0;
        1:       v[i*N +: N] = '1;
        2:       v[i*N +: N] = 32'h7FFF_FFFF;
        3:       v[i*N +: N] = 32'h8000_0000;
        default: v[i*N +: N] = $urandom;
      endcase
    end
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_valid"}, {{(W+1){1'b0}}, out_valid}, 1);
  endtask

  task automatic run_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [W-1:0] e_sum, input logic e_cout,
                         input logic e_ovf);
    int lat;
    @(negedge clk);
    a_i      = a;
    b_i      = b;
    cin_i    = cin;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, {{(W+1){1'b0}}, in_ready}, 1);
    @(negedge clk);
    in_valid = 1'b0;
    a_i      = ~a;
    b_i      = ~b;
    cin_i    = ~cin;
    wait_done(tag, lat);
    chk({tag, "_latency"}, lat, WORDS);
    chk({tag, "_sum"}, {2'b00, sum_o}, {2'b00, e_sum});
    chk({tag, "_cout"}, {{(W+1){1'b0}}, cout_o}, {{(W+1){1'b0}}, e_cout});
    chk({tag, "_ovf"}, {{(W+1){1'b0}}, ovf_o}, {{(W+1){1'b0}}, e_ovf});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle"}, {{(W+1){1'b0}}, in_ready}, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int           lat;
    int           acc;
    int           got;
    int           cyc;
    logic [W+1:0] exp;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_i       = '0;
    b_i       = '0;
    cin_i     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_in_ready",  {{(W+1){1'b0}}, in_ready}, 1);
    chk("rst_out_valid", {{(W+1){1'b0}}, out_valid}, 0);
    chk("rst_sum",       {2'b00, sum_o}, 0);
    chk("rst_cout",      {{(W+1){1'b0}}, cout_o}, 0);
    chk("rst_ovf",       {{(W+1){1'b0}}, ovf_o}, 0);

    run_txn("ones_plus_cin", {W{1'b1}}, '0, 1'b1, '0, 1'b1, 1'b0);
    run_txn("word_carry", 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1, 1'b0,
            128'h0000_0000_0000_0000_0000_0001_0000_0000, 1'b0, 1'b0);
    run_txn("pos_ovf", 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0,
            128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 1'b1);
    run_txn("neg_ovf", 128'h8000_0000_0000_0000_0000_0000_0000_0000,
            128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0, '0, 1'b1, 1'b1);

    // reset pulse while the third word is in flight
    @(negedge clk);
    a_i      = {W{1'b1}};
    b_i      = {W{1'b1}};
    cin_i    = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_in_run", {{W{1'b0}}, dbg_state}, {{W{1'b0}}, RUN});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_state",     {{W{1'b0}}, dbg_state}, {{W{1'b0}}, IDLE});
    chk("midrst_in_ready",  {{(W+1){1'b0}}, in_ready}, 1);
    chk("midrst_out_valid", {{(W+1){1'b0}}, out_valid}, 0);
    chk("midrst_sum",       {2'b00, sum_o}, 0);
    chk("midrst_cout",      {{(W+1){1'b0}}, cout_o}, 0);
    chk("midrst_ovf",       {{(W+1){1'b0}}, ovf_o}, 0);
    repeat (6) @(negedge clk);
    chk("midrst_no_result", {{(W+1){1'b0}}, out_valid}, 0);
    run_txn("after_rst", 128'h0123_4567_89AB_CDEF_0000_0000_0000_0001,
            128'h1111_1111_1111_1111_FFFF_FFFF_FFFF_FFFF, 1'b0,
            128'h1234_5678_9ABC_DF01_0000_0000_0000_0000, 1'b0, 1'b0);

    // backpressure: result held while a new pair is offered
    @(negedge clk);
    a_i      = 128'd5;
    b_i      = 128'd7;
    cin_i    = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done("bp_first", lat);
    a_i      = 128'd100;
    b_i      = 128'd200;
    cin_i    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {{(W+1){1'b0}}, out_valid}, 1);
      chk("bp_hold_ready", {{(W+1){1'b0}}, in_ready}, 0);
      chk("bp_hold_sum",   {2'b00, sum_o}, 12);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_ready", {{(W+1){1'b0}}, in_ready}, 1);
    chk("bp_idle_valid", {{(W+1){1'b0}}, out_valid}, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accepted", {{(W+1){1'b0}}, in_ready}, 0);
    wait_done("bp_second", lat);
    chk("bp_second_latency", lat, WORDS);
    chk("bp_second_sum", {2'b00, sum_o}, 300);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // random traffic with gaps on both sides
    acc = 0;
    got = 0;
    cyc = 0;
    while ((acc < 1000 || exp_q.size() > 0) && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      if (acc < 1000) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a_i      = rand_op();
        b_i      = rand_op();
        cin_i    = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_add(a_i, b_i, cin_i));
        acc++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_dup", {{(W+1){1'b0}}, out_valid}, 0);
        end else begin
          exp = exp_q.pop_front();
          chk("rand_res", {ovf_o, cout_o, sum_o}, exp);
          got++;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("rand_count", got, 1000);
    chk("rand_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rca_mw_adder.md
# rca_mw_adder

Multi-word sequential adder that sits around the team's N-bit ripple-carry adder. It accepts wide operands of N·WORDS bits over a valid/ready handshake and feeds them to a single `rca` instance one N-bit word per cycle, least-significant word first. Each word's carry-out is registered and fed back as the next word's carry-in. The assembled sum, carry-out and signed overflow are presented on a valid/ready output port.

## Interface
- `N`, 32, width of the `rca` instance (one word)
- `WORDS`, 4, words per operand; legal range ≥1; total width W = N·WORDS
- `clk`  in  1  clock; all state updates on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  operand pair offered
- `in_ready`  out  1  block can accept an operand pair
- `a_i`  in  W  operand A (unsigned / two's complement)
- `b_i`  in  W  operand B
- `cin_i`  in  1  carry-in to word 0
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer takes the result
- `sum_o`  out  W  A + B + cin, modulo 2^W
- `cout_o`  out  1  carry-out of the top word
- `ovf_o`  out  1  signed overflow of the W-bit addition

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- Registers: `a_q`, `b_q` (W each), `sum_q` (W), `carry_q`, `idx_q` (width max(1,$clog2(WORDS))), `ovf_q`.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, latch `a_q`/`b_q`, set `carry_q`←`cin_i` and `idx_q`←0, then go to RUN.
  - Operands are sampled only on the acceptance edge.
- **RUN**
  - `rca` inputs are word `idx_q` of `a_q` and `b_q` plus `carry_q`.
  - Each cycle: `sum_q[idx_q]`←rca sum and `carry_q`←rca cout.
  - If `idx_q`==WORDS-1: `ovf_q`←(a_top==b_top)&&(sum_top!=a_top), using the MSBs of the top word, then go to DONE. Otherwise `idx_q`++.
- **DONE**
  - `out_valid`=1.
  - `sum_o`=`sum_q`, `cout_o`=`carry_q`, `ovf_o`=`ovf_q`.
  - Outputs are held stable until `out_ready`; on `out_ready` go to IDLE.
- `in_ready` is asserted in IDLE only and is a pure function of state. `out_valid` is asserted in DONE only.
- A new operand pair is never accepted while a result is pending. No overlap between transactions.
- `sum_o`, `cout_o` and `ovf_o` are driven from registers only. There is no combinational path from any input to any output.
- WORDS=1: RUN lasts one cycle and `idx_q` stays 0.
- Reset mid-operation (RUN or DONE): the transaction is discarded and the FSM returns to IDLE on the next edge. No partial result is ever presented.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `sum_o`=0, `cout_o`=0, `ovf_o`=0. All internal registers are 0.
- Acceptance at edge T0 (IDLE, `in_valid`=1):
  - RUN covers the cycles ending at edges T1…T_WORDS.
  - `out_valid` rises after edge T_WORDS.
- Result consumed at edge Tc (`out_valid`&&`out_ready`): `in_ready`=1 after Tc, and the next acceptance can occur at Tc+1.
- Best-case throughput is one addition per WORDS+2 cycles.
- Critical path is one N-bit ripple chain plus the word mux. It does not grow with WORDS.

## Structure
- Package `rca_mw_pkg`:
  - `state_t` enum (IDLE, RUN, DONE)
  - helper function `idx_width(words)`
- Sub-module: the existing `rca` (N-bit combinational ripple-carry adder), instantiated exactly once. There are no other sub-modules.
- Word select uses indexed part-select `[idx_q*N +: N]`.

## Test plan
- A=2^128−1, B=0, cin=1 (N=32, WORDS=4) → `sum_o`=0, `cout_o`=1, `ovf_o`=0. `out_valid` rises exactly 4 cycles after acceptance.
- A=0x0000_0000_0000_0000_0000_0000_FFFF_FFFF, B=1, cin=0 → `sum_o`=0x…0001_0000_0000, `cout_o`=0. Checks carry crossing a word boundary.
- A=0x7FFF…FFFF, B=1, cin=0 → `sum_o`=0x8000…0000, `ovf_o`=1, `cout_o`=0. A=B=0x8000…0000 → `sum_o`=0, `cout_o`=1, `ovf_o`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while `in_valid`=1 with new operands → outputs are unchanged, `in_ready`=0 and the new pair is not accepted. Raise `out_ready` → IDLE next cycle, and the pair is accepted the cycle after.
- Pulse `rst` for 1 cycle during RUN (`idx_q`=2) → next cycle all outputs are at reset values and `in_ready`=1. A subsequent transaction completes correctly.
- 1000 random operand pairs and cin, with random `in_valid`/`out_ready` gaps → every result matches a 129-bit reference model (sum, cout, ovf). No result is lost or duplicated.
